// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store sequencer with sub-word extract and read-modify-write stores.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module dmem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   input  logic [31:0] mem_q
);
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
   state_t state, next;
   logic        we, sgn, acc, trap;
   logic [1:0]  size, off, a_off;
   logic [31:0] wdata, sh, ld, mask, merged;
   assign req_ready = state == IDLE;
   assign acc = req_valid && req_ready;
   always_comb begin
`ifdef MISALIGN_TRAP_EN
      a_off = req_addr[1:0];
      trap = req_size[1] ? |req_addr[1:0] : req_size[0] && req_addr[0];
`else
      a_off = req_size[1] ? 2'b00 : req_size[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
      trap = 1'b0;
`endif
   end
   always_comb begin
      next = state;
      case (state)
         IDLE: next = !acc ? IDLE : trap ? RESP : (req_we && req_size[1]) ? WR : RD;
         RD:   next = CAP;
         CAP:  next = we ? WR : RESP;
         WR:   next = RESP;
         RESP: next = IDLE;
         default: next = IDLE;
      endcase
   end
   // Lane offset is already aligned for halves, so one shift serves byte and half lanes.
   always_comb begin
      sh = mem_q >> {off, 3'b000};
      ld = size[1] ? mem_q : size[0] ? {{16{sgn & sh[15]}}, sh[15:0]} : {{24{sgn & sh[7]}}, sh[7:0]};
      mask = (size[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off, 3'b000};
      merged = (mem_q & ~mask) | ((wdata << {off, 3'b000}) & mask);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         mem_address <= '0;
         mem_data <= '0;
         mem_wren <= 1'b0;
         we <= 1'b0;
         sgn <= 1'b0;
         size <= '0;
         off <= '0;
         wdata <= '0;
      end else begin
         rsp_valid <= next == RESP;
         mem_wren <= next == WR;
         if (acc) begin
            we <= req_we;
            sgn <= req_signed;
            size <= req_size;
            off <= a_off;
            wdata <= req_wdata;
            rsp_err <= trap;
            rsp_rdata <= '0;
            mem_data <= req_wdata;
            if (!trap) mem_address <= {2'b00, req_addr[31:2]};
         end
         if (state == CAP) begin
            if (we) mem_data <= merged;
            else rsp_rdata <= ld;
         end
      end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed checks of dmem_access_unit against a synchronous dmem model.
module tb_dmem_access_unit;
   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_we = 0, req_signed = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, rsp_valid, rsp_err, mem_wren;
   logic [31:0] rsp_rdata, mem_address, mem_data, mem_q;
   logic [31:0] mem [0:63];
   logic        pre_we = 0;
   logic [5:0]  pre_a = 0;
   logic [31:0] pre_d = 0;
   int          wr_cnt = 0, n_cmp = 0, n_err = 0;
   logic [31:0] last_wa = 0, last_wd = 0;

   dmem_access_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_address(mem_address),
      .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      else if (mem_wren) begin
         mem[mem_address[5:0]] <= mem_data;
         wr_cnt <= wr_cnt + 1;
         last_wa <= mem_address;
         last_wd <= mem_data;
      end
      mem_q <= mem[mem_address[5:0]];
   end

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we = 1; pre_a = a; pre_d = d;
      @(negedge clk);
      pre_we = 0;
   endtask

   // Latency counts edges from the accept edge (1) to the edge that raises rsp_valid.
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
      @(negedge clk);
      req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      lat = 0; rd = 'x; err = 'x;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         req_valid = 0;
         if (rsp_valid) begin
            lat = k; rd = rsp_rdata; err = rsp_err;
            break;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL resp_one_cycle: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", {31'b0, rsp_err}, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_data", mem_data, 0);
      chk("rst_wren", {31'b0, mem_wren}, 0);
      rst = 0;
   endtask

   task automatic test_loads;
      int lat; logic [31:0] rd; logic err;
      issue(0, 2'b10, 0, 32'h28, 0, lat, rd, err);
      chk("lw_lat", lat, 3); chk("lw_data", rd, 32'h8899AABB); chk("lw_err", {31'b0, err}, 0);
      issue(0, 2'b00, 1, 32'h2B, 0, lat, rd, err);
      chk("lb_signed", rd, 32'hFFFFFF88); chk("lb_lat", lat, 3);
      issue(0, 2'b01, 0, 32'h28, 0, lat, rd, err);
      chk("lhu", rd, 32'h0000AABB);
      issue(0, 2'b01, 1, 32'h2A, 0, lat, rd, err);
      chk("lh_signed", rd, 32'hFFFF8899);
      issue(0, 2'b00, 0, 32'h29, 0, lat, rd, err);
      chk("lbu", rd, 32'h000000AA);
      issue(0, 2'b11, 0, 32'h28, 0, lat, rd, err);
      chk("l_reserved_word", rd, 32'h8899AABB);
   endtask

   task automatic test_misalign;
      int lat, w0; logic [31:0] rd; logic err;
      w0 = wr_cnt;
      issue(0, 2'b10, 0, 32'h2A, 0, lat, rd, err);
`ifdef MISALIGN_TRAP_EN
      chk("mis_lat", lat, 1); chk("mis_data", rd, 0); chk("mis_err", {31'b0, err}, 1);
`else
      chk("mis_lat", lat, 3); chk("mis_data", rd, 32'h8899AABB); chk("mis_err", {31'b0, err}, 0);
`endif
      chk("mis_no_write", wr_cnt - w0, 0);
   endtask

   task automatic test_store_rmw;
      int lat, w0; logic [31:0] rd; logic err;
      w0 = wr_cnt;
      issue(1, 2'b00, 0, 32'h29, 32'hFFFFFF11, lat, rd, err);
      chk("sb_lat", lat, 4); chk("sb_wr_count", wr_cnt - w0, 1);
      chk("sb_wr_addr", last_wa, 10); chk("sb_wr_data", last_wd, 32'h889911BB);
      chk("sb_rdata", rd, 0); chk("sb_mem", mem[10], 32'h889911BB);
      issue(1, 2'b01, 0, 32'h2A, 32'h0000CAFE, lat, rd, err);
      chk("sh_lat", lat, 4); chk("sh_mem", mem[10], 32'hCAFE11BB);
   endtask

   task automatic test_store_word;
      int lat, w0; logic [31:0] rd; logic err;
      w0 = wr_cnt;
      issue(1, 2'b10, 0, 32'h30, 32'h12345678, lat, rd, err);
      chk("sw_lat", lat, 2); chk("sw_wr_count", wr_cnt - w0, 1);
      chk("sw_mem", mem[12], 32'h12345678); chk("sw_rdata", rd, 0);
   endtask

   task automatic test_reset_abort;
      int w0, seen;
      w0 = wr_cnt; seen = 0;
      @(negedge clk);
      req_valid = 1; req_we = 1; req_size = 2'b00; req_addr = 32'h28; req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk); req_valid = 0;
      @(negedge clk);
      rst = 1;
      chk("abort_wren_in_rst", {31'b0, mem_wren}, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         seen += int'(rsp_valid | mem_wren);
      end
      rst = 0;
      @(negedge clk);
      chk("abort_ready", {31'b0, req_ready}, 1);
      for (int k = 0; k < 5; k++) begin
         seen += int'(rsp_valid | mem_wren);
         @(negedge clk);
      end
      chk("abort_no_activity", seen, 0);
      chk("abort_no_write", wr_cnt - w0, 0);
      chk("abort_mem", mem[10], 32'hCAFE11BB);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 0;
      test_reset;
      preload(10, 32'h8899AABB);
      test_loads;
      test_misalign;
      test_store_rmw;
      test_store_word;
      test_reset_abort;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1);
   end
endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The module SHALL expose these ports: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req_valid  input  1  pipeline MEM-stage request present.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 req_signed  input  1  sign-extend sub-word loads when 1.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  load result, extended per req_size and req_signed; 0 for stores.
REQ-013 rsp_err  output  1  misaligned-access flag, valid with rsp_valid.
REQ-014 mem_address  output  32  word index to dmem, equal to req_addr[31:2].
REQ-015 mem_data  output  32  write word to dmem.
REQ-016 mem_wren  output  1  dmem write enable.
REQ-017 mem_q  input  32  dmem read word, valid one cycle after dmem samples mem_address.

Function
REQ-018 All mem_* and rsp_* outputs SHALL be registered.
REQ-019 FSM states: IDLE, RD, CAP, WR, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1, and all request fields are latched then.
REQ-021 Load path: IDLE->RD (mem_address driven, mem_wren=0) -> CAP (mem_q valid) -> RESP; rsp_valid SHALL rise 3 cycles after the accept edge.
REQ-022 Word store: IDLE->WR (mem_wren=1, mem_data=req_wdata) -> RESP; rsp_valid SHALL rise 2 cycles after accept.
REQ-023 Byte/half store (read-modify-write): IDLE->RD->CAP->WR->RESP; in CAP the unit SHALL merge the low lane(s) of req_wdata into mem_q at byte lane addr[1:0] (little-endian), leaving other bytes unchanged; rsp_valid SHALL rise 4 cycles after accept.
REQ-024 Loads SHALL extract byte lane addr[1:0], or half lane addr[1], then zero- or sign-extend to 32 bits.
REQ-025 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_valid carries no backpressure.
REQ-026 mem_wren SHALL be 1 only in WR, for exactly one cycle per store.
REQ-027 A req_valid arriving while req_ready=0 SHALL be ignored; the requester holds it until accepted.
REQ-028 mem_address SHALL hold its value from RD through WR of an RMW, so the write returns to the word that was read.

Reset
REQ-029 While rst=1, regardless of clk: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_address=0; mem_data=0; mem_wren=0.
REQ-030 Reset asserted mid-transaction SHALL abort it: no write issued and no rsp_valid produced for that transaction.

Configuration
REQ-031 The macro MISALIGN_TRAP_EN SHALL control misalignment handling: defined -> a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes IDLE->RESP with rsp_err=1, rsp_rdata=0, and no mem_wren; undefined -> the offending low address bits are forced to 0 and the access proceeds, with rsp_err tied to 0.

Verification
REQ-032 Preload dmem word 10=0x8899AABB; load word at addr 0x28 -> rsp_valid 3 cycles after accept, rsp_rdata=0x8899AABB, rsp_err=0.
REQ-033 Same word; signed byte load at 0x2B -> 0xFFFFFF88; unsigned half load at 0x28 -> 0x0000AABB.
REQ-034 Byte store 0x11 at 0x29 -> exactly one mem_wren pulse at word 10 with data 0x889911BB; rsp_valid 4 cycles after accept.
REQ-035 Word load at 0x2A -> with MISALIGN_TRAP_EN: rsp_err=1, rsp_rdata=0, no dmem access; without it: rsp_rdata=0x8899AABB.
REQ-036 Assert rst in CAP of an RMW byte store -> mem_wren never asserts, dmem word unchanged, no rsp_valid, req_ready=1 on the cycle after reset release.
